tinycpu_stack: RTL
==================

Name: tinycpu_stack

Overview:
Operand stack for the tinycpu datapath. It sits directly upstream of the ALU and the out/memory paths and supplies qtop and qnext as operands. The control sequencer writes it through push, pop and load, and ALU/dbus results return on d. It also reports occupancy and keeps sticky overflow/underflow flags so that benches can check stack discipline in programs such as subtract.

Parameters:
WIDTH, 16, data width of each entry (matches dbus/qtop)
DEPTH, 8, number of entries (any value >= 2)
CNTW, 4, width of count; must satisfy 2^CNTW > DEPTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
push  input  1  push d as new top
pop  input  1  discard top
load  input  1  overwrite top with d
clr_err  input  1  clear sticky ovf/unf
d  input  WIDTH  write data (ALU result / dbus / in)
qtop  output  WIDTH  top entry, combinational from registered state
qnext  output  WIDTH  entry below top
count  output  CNTW  number of valid entries, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
ovf  output  1  sticky overflow
unf  output  1  sticky underflow

Behaviour:
- Reset, synchronous, active-high:
  - Takes priority over every other input.
  - At the edge it sets count=0, ovf=0, unf=0 and clears all entries to 0.
  - After reset: qtop=0, qnext=0, empty=1, full=0.
- Storage and reads:
  - Register array mem[0..DEPTH-1]; mem[count-1] is the top.
  - qtop = (count>=1) ? mem[count-1] : 0.
  - qnext = (count>=2) ? mem[count-2] : 0.
  - Reads are combinational, so results are visible in the cycle after the edge that performs the operation.
- Operation decode, evaluated each edge with priority high to low:
  - push&pop (replace): if count>=1, mem[count-1]<=d and count is unchanged. If count==0, set unf and make no other change.
  - push: if count<DEPTH, mem[count]<=d and count<=count+1. If full, set ovf, drop d, no other change.
  - pop: if count>=1, count<=count-1; the vacated entry is not cleared. If empty, set unf, no other change.
  - load (only when push=pop=0): if count>=1, mem[count-1]<=d. If empty, set unf, no other change.
  - none asserted: hold.
- Sticky flags:
  - ovf/unf stay at 1 until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
  - clr_err does not affect data or count.
- A binary ALU op is issued as two cycles: pop, then load with the result. This sequence never underflows when count>=2 at the start.
- Width rules:
  - d is stored unmodified; there is no arithmetic inside the block.
  - count never wraps; it saturates at the guarded 0/DEPTH boundaries.
- No X must reach qtop/qnext after reset for any input sequence.

Test Plan:
- Reset with push=1, d=5 asserted during reset cycle -> count=0, qtop=0, empty=1, ovf=unf=0 after the edge.
- push d=3, then push d=7 -> qtop=7, qnext=3, count=2. Then pop, then load d=4 (7-3 subtract sequence) -> qtop=4, qnext=0, count=1, unf=0.
- push&pop with count=2 (top 7, below 3), d=9 -> qtop=9, qnext=3, count=2. push&pop at count=0 -> unf=1, count=0.
- Push 1..8 (DEPTH=8) -> full=1, count=8, qtop=8. Push 9 -> ovf=1, qtop=8, count=8. Pop -> qtop=7, full=0, ovf remains 1.
- From empty, pop -> unf=1, count=0, qtop=0. Next cycle load d=2 with clr_err=1 -> unf=1 (set wins), count=0. Next cycle clr_err=1 only -> unf=0.
- Push 10,11,12, then reset during a pop cycle -> count=0, qtop=0, qnext=0. Push 6 afterwards -> qtop=6, qnext=0, count=1.

Source files
------------

// File: rtl/tinycpu_stack_if.sv
// Control/data bundle between the tinycpu sequencer and its operand stack.
// The sequencer drives commands and write data; the stack returns operands and status.
interface tinycpu_stack_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
);
  logic             push;
  logic             pop;
  logic             load;
  logic             clr_err;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] qtop;
  logic [WIDTH-1:0] qnext;
  logic [CNTW-1:0]  count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, load, clr_err, d,
    input  qtop, qnext, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, load, clr_err, d,
    output qtop, qnext, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/tinycpu_stack.sv
// Operand stack feeding the tinycpu ALU: push/pop/load/replace with
// saturating occupancy and sticky overflow/underflow flags.
module tinycpu_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  tinycpu_stack_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNTW-1:0]  cnt;
  logic             ovf_q;
  logic             unf_q;

  logic             has1;
  logic             has2;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    next_idx;

  assign has1     = (cnt != '0);
  assign has2     = (cnt >= CNTW'(2));
  assign is_full  = (cnt == CNTW'(DEPTH));
  assign top_idx  = AW'(cnt - CNTW'(1));
  assign next_idx = AW'(cnt - CNTW'(2));

  // Decoded next-state for one edge.
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [CNTW-1:0]  cnt_nxt;
  logic             set_ovf;
  logic             set_unf;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    cnt_nxt = cnt;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (bus.push && bus.pop) begin
      if (has1) wr_en   = 1'b1;
      else      set_unf = 1'b1;
    end else if (bus.push) begin
      if (!is_full) begin
        wr_en   = 1'b1;
        wr_idx  = AW'(cnt);
        cnt_nxt = cnt + CNTW'(1);
      end else begin
        set_ovf = 1'b1;
      end
    end else if (bus.pop) begin
      if (has1) cnt_nxt = cnt - CNTW'(1);
      else      set_unf = 1'b1;
    end else if (bus.load) begin
      if (has1) wr_en   = 1'b1;
      else      set_unf = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      // NOTE: the entry array is cleared on reset on purpose, so that no
      // uninitialised entry can ever surface on qtop/qnext.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (wr_en) mem[wr_idx] <= bus.d;
      // A new error in the same cycle as clr_err wins.
      if (set_ovf)          ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
      if (set_unf)          unf_q <= 1'b1;
      else if (bus.clr_err) unf_q <= 1'b0;
    end
  end

  assign bus.qtop  = has1 ? mem[top_idx]  : '0;
  assign bus.qnext = has2 ? mem[next_idx] : '0;
  assign bus.count = cnt;
  assign bus.empty = !has1;
  assign bus.full  = is_full;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule
